// File: rtl/mem_pkg.sv
// Shared types and defaults for the word-addressed RAM responder.
package mem_pkg;

    localparam int unsigned WORD_WIDTH    = 32;
    localparam int unsigned DEF_ADDR_BITS = 9;
    localparam int unsigned DEF_LATENCY   = 2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic {OP_READ, OP_WRITE} op_e;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port storage; contents are never reset, only the read register is.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                  i_clock,
    input  logic                  i_clear,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_BITS-1:0]  i_addr,
    input  logic [WORD_WIDTH-1:0] i_din,
    output logic [WORD_WIDTH-1:0] o_dout
);

    logic [WORD_WIDTH-1:0] r_mem [2**ADDR_BITS];
    logic [WORD_WIDTH-1:0] r_dout;

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_din;
        end
    end

    // Read data holds across writes so the last read value stays visible.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_dout <= '0;
        end else if (i_re) begin
            r_dout <= r_mem[i_addr];
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/mem_responder.sv
// RAM end of the read/write/finished four-phase handshake with programmable wait states.
// Define MEM_BOUNDS_CHECK_EN to flag and suppress accesses above the decoded address range.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
    parameter int unsigned LATENCY   = DEF_LATENCY
) (
    input  logic                  i_clock,
    input  logic                  i_clear,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [31:0]           i_address,
    input  logic [WORD_WIDTH-1:0] i_wdata,
    output logic [WORD_WIDTH-1:0] o_rdata,
    output logic                  o_finished,
    output logic                  o_fault
);

    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_e                r_state, w_state_next;
    logic [CntW-1:0]       r_cnt, w_cnt_next;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [WORD_WIDTH-1:0] r_wdata;
    op_e                   r_op;
    logic                  r_oob;
    logic                  r_rd_zero;

    logic                  w_req;
    op_e                   w_in_op;
    logic                  w_in_oob;
    logic                  w_access;
    logic [ADDR_BITS-1:0]  w_acc_addr;
    logic [WORD_WIDTH-1:0] w_acc_wdata;
    op_e                   w_acc_op;
    logic                  w_acc_oob;
    logic                  w_we;
    logic                  w_re;
    logic [WORD_WIDTH-1:0] w_dout;

    assign w_req   = i_read | i_write;
    assign w_in_op = i_read ? OP_READ : OP_WRITE;

`ifdef MEM_BOUNDS_CHECK_EN
    assign w_in_oob = |i_address[31:ADDR_BITS];
`else
    logic w_unused_addr;
    assign w_unused_addr = ^i_address[31:ADDR_BITS];
    assign w_in_oob      = 1'b0;
`endif

    // With zero latency the access happens on the capture edge, so use the live inputs.
    assign w_acc_addr  = (r_state == IDLE) ? i_address[ADDR_BITS-1:0] : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? i_wdata : r_wdata;
    assign w_acc_op    = (r_state == IDLE) ? w_in_op : r_op;
    assign w_acc_oob   = (r_state == IDLE) ? w_in_oob : r_oob;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_access     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (LATENCY == 0) begin
                        w_access     = 1'b1;
                        w_state_next = DONE;
                    end else begin
                        w_cnt_next   = CntLoad;
                        w_state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_access     = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            DONE: begin
                if (!w_req) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Clear must also block the storage write of an access due on the same edge.
    assign w_we = w_access && !i_clear && (w_acc_op == OP_WRITE) && !w_acc_oob;
    assign w_re = w_access && !i_clear && (w_acc_op == OP_READ);

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rd_zero <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_re) begin
                r_rd_zero <= w_acc_oob;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (r_state == IDLE && w_req) begin
            r_addr  <= i_address[ADDR_BITS-1:0];
            r_wdata <= i_wdata;
            r_op    <= w_in_op;
            r_oob   <= w_in_oob;
        end
    end

    mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem_array (
        .i_clock (i_clock),
        .i_clear (i_clear),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_acc_addr),
        .i_din   (w_acc_wdata),
        .o_dout  (w_dout)
    );

    assign o_rdata    = r_rd_zero ? '0 : w_dout;
    assign o_finished = (r_state == DONE);

`ifdef MEM_BOUNDS_CHECK_EN
    assign o_fault = (r_state == DONE) && r_oob;
`else
    assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected responses, a monitor checks them.
module tb_mem_responder;

    localparam int unsigned LAT = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        clear, rd, wr, rd0, wr0;
    logic [31:0] addr, wd, addr0, wd0;
    logic [31:0] rdata, rdata0;
    logic        fin, fin0, flt, flt0;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb_q[$];
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_BITS (9),
        .LATENCY   (LAT)
    ) dut (
        .i_clock    (clk),
        .i_clear    (clear),
        .i_read     (rd),
        .i_write    (wr),
        .i_address  (addr),
        .i_wdata    (wd),
        .o_rdata    (rdata),
        .o_finished (fin),
        .o_fault    (flt)
    );

    mem_responder #(
        .ADDR_BITS (9),
        .LATENCY   (0)
    ) dut0 (
        .i_clock    (clk),
        .i_clear    (clear),
        .i_read     (rd0),
        .i_write    (wr0),
        .i_address  (addr0),
        .i_wdata    (wd0),
        .o_rdata    (rdata0),
        .o_finished (fin0),
        .o_fault    (flt0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: each rising finished consumes one scoreboard entry.
    logic prev_fin = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (fin === 1'b1 && prev_fin !== 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_finished: got finished with empty scoreboard");
            end else begin
                mon_e = sb_q.pop_front();
                check("rdata", rdata, mon_e.rdata);
                check("fault", {31'b0, flt}, {31'b0, mon_e.fault});
            end
        end
        prev_fin = fin;
    end

    task automatic push_exp(input logic r, input logic [31:0] mem_val, input logic f);
        exp_t e;
        e.rdata = r ? mem_val : last_rd;
        e.fault = f;
        if (r) last_rd = mem_val;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input logic pert, input logic [31:0] a2, input logic [31:0] d2);
        int n = 0;
        while (fin !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (pert && n == 1) begin
                addr = a2;
                wd   = d2;
            end
        end
        check("latency", 32'(n), 32'(LAT + 1));
        rd = 1'b0;
        wr = 1'b0;
        @(posedge clk); #1;
        check("release", {31'b0, fin}, 32'd0);
    endtask

    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] mem_val, input logic f,
                          input logic pert, input logic [31:0] a2, input logic [31:0] d2);
        push_exp(r, mem_val, f);
        rd   = r;
        wr   = w;
        addr = a;
        wd   = d;
        wait_done(pert, a2, d2);
    endtask

    initial begin
        clear = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wd = '0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wd0 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_finished", {31'b0, fin}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_fault", {31'b0, flt}, 32'd0);
        check("rst_finished0", {31'b0, fin0}, 32'd0);
        clear = 1'b0;

        // Known background contents.
        access(1'b0, 1'b1, 32'h03, 32'h3333, '0, 1'b0, 1'b0, '0, '0);
        access(1'b0, 1'b1, 32'h0B, 32'hBBBB, '0, 1'b0, 1'b0, '0, '0);
        access(1'b0, 1'b1, 32'h20, 32'h2020, '0, 1'b0, 1'b0, '0, '0);
        access(1'b0, 1'b1, 32'h00, 32'hA0A0, '0, 1'b0, 1'b0, '0, '0);
        access(1'b1, 1'b0, 32'h03, '0, 32'h3333, 1'b0, 1'b0, '0, '0);

        // Clear held two cycles with a read pending, then the read proceeds.
        rd = 1'b1; addr = 32'h03; clear = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("clr_finished", {31'b0, fin}, 32'd0);
        check("clr_rdata", rdata, 32'd0);
        check("clr_fault", {31'b0, flt}, 32'd0);
        last_rd = '0;
        push_exp(1'b1, 32'h3333, 1'b0);
        clear = 1'b0;
        wait_done(1'b0, '0, '0);

        access(1'b0, 1'b1, 32'h05, 32'hDEADBEEF, '0, 1'b0, 1'b0, '0, '0);
        access(1'b1, 1'b0, 32'h05, '0, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);

        // Inputs changed while BUSY are ignored.
        access(1'b0, 1'b1, 32'h0A, 32'h11, '0, 1'b0, 1'b1, 32'h0B, 32'h22);
        access(1'b1, 1'b0, 32'h0A, '0, 32'h11, 1'b0, 1'b0, '0, '0);
        access(1'b1, 1'b0, 32'h0B, '0, 32'hBBBB, 1'b0, 1'b0, '0, '0);

        // Read and write together resolve as a read.
        access(1'b0, 1'b1, 32'h05, 32'h1234, '0, 1'b0, 1'b0, '0, '0);
        access(1'b1, 1'b1, 32'h05, 32'h9999, 32'h1234, 1'b0, 1'b0, '0, '0);
        access(1'b1, 1'b0, 32'h05, '0, 32'h1234, 1'b0, 1'b0, '0, '0);

        // Clear during BUSY aborts the write.
        wr = 1'b1; addr = 32'h20; wd = 32'h5555;
        @(posedge clk); #1;
        clear = 1'b1; wr = 1'b0;
        @(posedge clk); #1;
        check("abort_finished", {31'b0, fin}, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        last_rd = '0;
        clear = 1'b0;
        access(1'b1, 1'b0, 32'h20, '0, 32'h2020, 1'b0, 1'b0, '0, '0);

        // Zero-latency instance completes in one edge.
        wr0 = 1'b1; addr0 = 32'h20; wd0 = 32'h7777;
        @(posedge clk); #1;
        check("lat0_wr_finished", {31'b0, fin0}, 32'd1);
        check("lat0_fault", {31'b0, flt0}, 32'd0);
        wr0 = 1'b0;
        @(posedge clk); #1;
        check("lat0_wr_release", {31'b0, fin0}, 32'd0);
        rd0 = 1'b1;
        @(posedge clk); #1;
        check("lat0_rd_finished", {31'b0, fin0}, 32'd1);
        check("lat0_rdata", rdata0, 32'h7777);
        rd0 = 1'b0;
        @(posedge clk); #1;
        check("lat0_rd_release", {31'b0, fin0}, 32'd0);

`ifdef MEM_BOUNDS_CHECK_EN
        access(1'b0, 1'b1, 32'h200, 32'hF00D, '0, 1'b1, 1'b0, '0, '0);
        access(1'b1, 1'b0, 32'h000, '0, 32'hA0A0, 1'b0, 1'b0, '0, '0);
        access(1'b1, 1'b0, 32'h200, '0, 32'h0, 1'b1, 1'b0, '0, '0);
`else
        access(1'b0, 1'b1, 32'h200, 32'hF00D, '0, 1'b0, 1'b0, '0, '0);
        access(1'b1, 1'b0, 32'h000, '0, 32'hF00D, 1'b0, 1'b0, '0, '0);
        access(1'b1, 1'b0, 32'h200, '0, 32'hF00D, 1'b0, 1'b0, '0, '0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
